// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for a 16-entry, 1-bit LUT.
// Receives a parity-protected frame, commits it on good parity, then sweeps the LUT address.
module lut_cfg_loader #(
    parameter int CFG_W  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_bit,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] a_sel,
    output logic [CFG_W-1:0]  ram,
    output logic              ram_vld,
    output logic              a0,
    output logic              a1,
    output logic              a2,
    output logic              a3,
    output logic              busy,
    output logic              err,
    output logic              sweep_done
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(CFG_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_SWEEP = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CFG_W-1:0]   shadow_r, shadow_s;
    logic               par_r, par_s;
    logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
    logic [ADDR_W-1:0]  sweep_cnt_r, sweep_cnt_s;
    logic [CFG_W-1:0]   ram_r, ram_s;
    logic               ram_vld_r, ram_vld_s;
    logic               err_r, err_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic               sweep_done_r, sweep_done_s;
    logic               cfg_ready_r;
    logic               busy_r;

    // Even parity over data plus parity bit: true when the total XOR is zero.
    function automatic logic even_parity_ok(input logic [CFG_W-1:0] data, input logic par);
        return ((^data) ^ par) == 1'b0;
    endfunction

    // Next-state, datapath and address-mux logic.
    always_comb begin
        state_s     = state_r;
        shadow_s    = shadow_r;
        par_s       = par_r;
        bit_cnt_s   = bit_cnt_r;
        sweep_cnt_s = sweep_cnt_r;
        ram_s       = ram_r;
        ram_vld_s   = ram_vld_r;
        err_s       = err_r;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_s   = ST_SHIFT;
                    err_s     = 1'b0;
                    bit_cnt_s = '0;
                    shadow_s  = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Restart wins over any beat presented in the same cycle.
                if (cfg_start) begin
                    err_s     = 1'b0;
                    bit_cnt_s = '0;
                    shadow_s  = '0;
                end else if (cfg_valid) begin
                    if (bit_cnt_r == LAST_BEAT) begin
                        par_s   = cfg_bit;
                        state_s = ST_CHECK;
                    end else begin
                        shadow_s  = {shadow_r[CFG_W-2:0], cfg_bit};
                        bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_CHECK: begin
                if (even_parity_ok(shadow_r, par_r)) begin
                    ram_s       = shadow_r;
                    ram_vld_s   = 1'b1;
                    sweep_cnt_s = '0;
                    state_s     = ST_SWEEP;
                end else begin
                    err_s   = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (sweep_cnt_r == LAST_ADDR) begin
                    state_s = ST_IDLE;
                end else begin
                    sweep_cnt_s = sweep_cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (state_s == ST_SWEEP) begin
            addr_s       = sweep_cnt_s;
            sweep_done_s = (sweep_cnt_s == LAST_ADDR);
        end else begin
            addr_s       = a_sel;
            sweep_done_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            shadow_r     <= '0;
            par_r        <= 1'b0;
            bit_cnt_r    <= '0;
            sweep_cnt_r  <= '0;
            ram_r        <= '0;
            ram_vld_r    <= 1'b0;
            err_r        <= 1'b0;
            addr_r       <= a_sel;
            sweep_done_r <= 1'b0;
            cfg_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shadow_r     <= shadow_s;
            par_r        <= par_s;
            bit_cnt_r    <= bit_cnt_s;
            sweep_cnt_r  <= sweep_cnt_s;
            ram_r        <= ram_s;
            ram_vld_r    <= ram_vld_s;
            err_r        <= err_s;
            addr_r       <= addr_s;
            sweep_done_r <= sweep_done_s;
            cfg_ready_r  <= (state_s == ST_SHIFT);
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    assign cfg_ready        = cfg_ready_r;
    assign busy             = busy_r;
    assign ram              = ram_r;
    assign ram_vld          = ram_vld_r;
    assign err              = err_r;
    assign sweep_done       = sweep_done_r;
    assign {a0, a1, a2, a3} = addr_r;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Self-checking bench for lut_cfg_loader: directed vector table, corner sequences
// and randomized frames against a frame-level reference model.
module tb_lut_cfg_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        cfg_bit;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  a_sel;
    logic [15:0] ram;
    logic        ram_vld;
    logic        a0, a1, a2, a3;
    logic        busy;
    logic        err;
    logic        sweep_done;
    logic [3:0]  addr_w;

    int tests  = 0;
    int failed = 0;

    // Frame-level reference state
    logic [15:0] m_ram;
    logic        m_vld;
    logic        m_err;

    typedef struct {
        logic [15:0] data;
        logic        par;
        logic        stall;
        logic [15:0] exp_ram;
        logic        exp_vld;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    assign addr_w = {a0, a1, a2, a3};

    always #5 clk = ~clk;

    lut_cfg_loader #(.CFG_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .a_sel      (a_sel),
        .ram        (ram),
        .ram_vld    (ram_vld),
        .a0         (a0),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .busy       (busy),
        .err        (err),
        .sweep_done (sweep_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // mode 0: no stalls, 1: 3-cycle stalls after beats 4 and 11, 2: random stalls
    task automatic send_frame(input logic [15:0] data, input logic par, input int mode);
        int n;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("ready_in_shift", {31'd0, cfg_ready}, 32'd1);
        for (int i = 0; i < 17; i++) begin
            cfg_bit   = (i < 16) ? data[15-i] : par;
            cfg_valid = 1'b1;
            tick();
            n = 0;
            if (mode == 1 && (i == 4 || i == 11)) n = 3;
            else if (mode == 2 && i < 16 && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
            if (i < 16 && n > 0) begin
                cfg_valid = 1'b0;
                for (int s = 0; s < n; s++) begin
                    cfg_bit = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    // Checks the sweep (or its absence) and final committed state after a frame.
    task automatic post_frame(input logic [15:0] exp_ram, input logic exp_vld, input logic exp_err);
        if (!exp_err) begin
            for (int i = 0; i < 4 && addr_w != 4'd0; i++) tick();
            chk("ram_at_sweep0", {16'd0, ram}, {16'd0, exp_ram});
            for (int k = 0; k < 16; k++) begin
                chk("sweep_addr", {28'd0, addr_w}, k);
                chk("sweep_done", {31'd0, sweep_done}, (k == 15) ? 32'd1 : 32'd0);
                chk("busy_sweep", {31'd0, busy}, 32'd1);
                tick();
            end
            chk("busy_after_sweep", {31'd0, busy}, 32'd0);
            chk("done_after_sweep", {31'd0, sweep_done}, 32'd0);
        end else begin
            tick();
            tick();
            chk("no_sweep_busy", {31'd0, busy}, 32'd0);
        end
        wait_idle();
        chk("ram", {16'd0, ram}, {16'd0, exp_ram});
        chk("ram_vld", {31'd0, ram_vld}, {31'd0, exp_vld});
        chk("err", {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[1] = '{16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b1, 1'b0};
        vecs[2] = '{16'hA5C3, 1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b1};
        vecs[3] = '{16'hA5C3, 1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b0};
        vecs[4] = '{16'h0000, 1'b1, 1'b0, 16'hA5C3, 1'b1, 1'b1};
        vecs[5] = '{16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8001, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};

        rst = 1'b1; cfg_start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0; a_sel = 4'b1010;
        tick();
        tick();
        chk("rst_ram", {16'd0, ram}, 32'd0);
        chk("rst_vld", {31'd0, ram_vld}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // Pass-through of the user address while idle
        a_sel = 4'b1010;
        tick();
        chk("pass_1010", {28'd0, addr_w}, 32'hA);
        a_sel = 4'b0111;
        tick();
        chk("pass_0111", {28'd0, addr_w}, 32'h7);
        chk("idle_ready", {31'd0, cfg_ready}, 32'd0);
        a_sel = 4'b1010;

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stall ? 1 : 0);
            post_frame(vecs[v].exp_ram, vecs[v].exp_vld, vecs[v].exp_err);
        end

        // Abort after 7 beats, restart with cfg_valid held high, then full frame
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cfg_bit = 1'b1; cfg_valid = 1'b1;
            tick();
        end
        send_frame(16'h1234, 1'b1, 0);
        post_frame(16'h1234, 1'b1, 1'b0);

        // Reset after 9 beats
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cfg_bit = 1'b1; cfg_valid = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_ram", {16'd0, ram}, 32'd0);
        chk("midrst_vld", {31'd0, ram_vld}, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, cfg_ready}, 32'd0);
        chk("midrst_addr", {28'd0, addr_w}, 32'hA);
        rst = 1'b0;
        tick();

        // Randomized frames with stalls and aborts against the frame-level model
        m_ram = 16'h0000; m_vld = 1'b0; m_err = 1'b0;
        for (int f = 0; f < 40; f++) begin
            logic [15:0] d;
            logic        p;
            d = 16'($urandom);
            p = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 3) == 0) p = ~p;
            if ($urandom_range(0, 5) == 0) begin
                cfg_start = 1'b1;
                tick();
                cfg_start = 1'b0;
                for (int i = 0; i < int'($urandom_range(1, 15)); i++) begin
                    cfg_bit = 1'($urandom_range(0, 1)); cfg_valid = 1'b1;
                    tick();
                end
            end
            send_frame(d, p, 2);
            if ($countones({d, p}) % 2 == 0) begin
                m_ram = d; m_vld = 1'b1; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            tick();
            wait_idle();
            chk("rnd_ram", {16'd0, ram}, {16'd0, m_ram});
            chk("rnd_vld", {31'd0, ram_vld}, {31'd0, m_vld});
            chk("rnd_err", {31'd0, err}, {31'd0, m_err});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
Upstream configuration stage for the 16-entry, 1-bit LUT. It accepts a serial configuration frame of 16 data bits plus 1 even-parity bit over a valid/ready handshake, and commits the frame to the LUT's RAM[15:0] bus only when parity checks. After each successful commit it sweeps the LUT address lines a0..a3 through all 16 entries so downstream logic can read back the new contents. Outside a sweep, it passes a user address through to a0..a3.

Parameters:
CFG_W, 16, LUT contents width; number of data bits per frame.
ADDR_W, 4, LUT address width; CFG_W = 2**ADDR_W.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
cfg_start  in  1  single-cycle pulse; begins a new frame
cfg_bit  in  1  serial config data; MSB first, parity bit last
cfg_valid  in  1  cfg_bit is valid this cycle
cfg_ready  out  1  loader accepts cfg_bit this cycle
a_sel  in  ADDR_W  user LUT address, used when not sweeping
ram  out  CFG_W  committed LUT contents; drives the LUT RAM input
ram_vld  out  1  ram holds a committed frame
a0  out  1  LUT address bit 3 (MSB)
a1  out  1  LUT address bit 2
a2  out  1  LUT address bit 1
a3  out  1  LUT address bit 0 (LSB)
busy  out  1  high in every state except IDLE
err  out  1  sticky parity error
sweep_done  out  1  one-cycle pulse on the last sweep address

Behaviour:
- Reset (rst=1 at a clk edge) has priority over all other inputs, including mid-frame and mid-sweep. On reset:
  - state=IDLE; ram=0; ram_vld=0; err=0; sweep_done=0; cfg_ready=0; busy=0.
  - Shift register and bit counter cleared.
  - {a0,a1,a2,a3} follows a_sel.
- FSM states: IDLE, SHIFT, CHECK, SWEEP.
- IDLE:
  - cfg_ready=0.
  - cfg_start=1 → SHIFT; clears err, counter=0.
  - cfg_valid is ignored.
- SHIFT:
  - cfg_ready=1.
  - A beat transfers when cfg_valid and cfg_ready are both 1.
  - Beats 0..15 shift into the shadow register MSB first, so beat 0 ends at ram bit 15.
  - Beat 16 is the parity bit → CHECK.
  - A cycle with cfg_valid=0 is a stall: no state change.
  - cfg_start=1 in SHIFT aborts and restarts: counter=0, shadow=0, err=0, stays in SHIFT; any cfg_valid in that cycle is ignored.
- CHECK (exactly 1 cycle):
  - cfg_ready=0.
  - Parity is the XOR of the 16 data bits and the parity bit.
  - XOR=0 → ram<=shadow, ram_vld<=1, sweep counter=0, go to SWEEP.
  - XOR=1 → err<=1; ram and ram_vld unchanged; go to IDLE.
- SWEEP:
  - {a0,a1,a2,a3} = sweep counter, incrementing 0→15, one address per cycle (16 cycles).
  - sweep_done=1 in the cycle with address 15, then → IDLE.
  - cfg_start is ignored during SWEEP. cfg_ready=0.
- Address mux: {a0,a1,a2,a3} is registered. It equals the sweep counter in SWEEP, otherwise a_sel from the previous cycle (1-cycle latency).
- Commit latency: parity beat accepted at edge N → CHECK during cycle N+1 → new ram and sweep address 0 visible after edge N+2.
- ram changes only on a successful CHECK; between commits it holds its value indefinitely.
- err stays high until the next cfg_start or rst.
- Counters never wrap silently:
  - Bit counter saturates at 16 and forces CHECK.
  - Sweep counter stops at 15.

Test Plan:
- Reset values: assert rst for 2 cycles mid-run → ram=0x0000, ram_vld=0, err=0, busy=0, cfg_ready=0.
- Good load: cfg_start, then 0xA5C3 MSB first plus parity 0 (popcount 8) → ram=0xA5C3, ram_vld=1; {a0..a3} steps 0000..1111 on 16 consecutive cycles; sweep_done high only at 1111; busy falls the next cycle.
- Bad parity: the same frame with parity 1 → err=1, ram keeps its prior value (0xA5C3 or 0x0000), ram_vld unchanged, no sweep.
- Stalls: the same good frame with cfg_valid deasserted for 3 cycles after beats 4 and 11 → identical ram=0xA5C3; no extra bits captured.
- Abort and reset: cfg_start after 7 beats, then a full frame 0x1234 with parity 1 → ram=0x1234. Separately, rst after 9 beats → IDLE, ram=0.
- Pass-through: in IDLE, a_sel=4'b1010 → next cycle a0=1, a1=0, a2=1, a3=0. a_sel=4'b0111 → a0=0, a1=1, a2=1, a3=1.
